// File: rtl/vpu_dst_port_if.sv
// vpu_dst_port_if
//   Bundles the result-input and line-output signals of vpu_dst_port.
//   clk and rst_n are plain ports on the module itself.
//
//   Producer side : result_i, done_i, flush_i, ovf_clr_i
//   Line side     : wr_data_o, wr_mask_o, wr_valid_o, wr_ready_i
//   Status        : busy_o, overflow_o
//
//   Modports
//     master : the environment (producer, downstream and status consumer)
//     slave  : the vpu_dst_port instance
interface vpu_dst_port_if #(
  parameter int OPERAND_WIDTH = 32,
  parameter int LANES         = 4
);
  logic [OPERAND_WIDTH-1:0]       result_i;
  logic                           done_i;
  logic                           flush_i;
  logic [LANES*OPERAND_WIDTH-1:0] wr_data_o;
  logic [LANES-1:0]               wr_mask_o;
  logic                           wr_valid_o;
  logic                           wr_ready_i;
  logic                           busy_o;
  logic                           overflow_o;
  logic                           ovf_clr_i;

  modport master (
    output result_i, done_i, flush_i, wr_ready_i, ovf_clr_i,
    input  wr_data_o, wr_mask_o, wr_valid_o, busy_o, overflow_o
  );

  modport slave (
    input  result_i, done_i, flush_i, wr_ready_i, ovf_clr_i,
    output wr_data_o, wr_mask_o, wr_valid_o, busy_o, overflow_o
  );
endinterface

// File: rtl/vpu_dst_port.sv
// vpu_dst_port
//   Collects FP results from an upstream unit, which cannot be stalled,
//   into a small FIFO. It packs them LANES at a time into one output line
//   and offers each line downstream with a valid/ready handshake. A flush
//   request emits a partially filled line. Lanes that were not filled are
//   zero and are masked off.
//
//   Ports
//     clk    : single clock; all logic runs on the rising edge
//     rst_n  : asynchronous, active-low reset
//     bus    : vpu_dst_port_if.slave
//       result_i/done_i : incoming result and its valid strobe
//       flush_i         : one-cycle request to emit the partial line
//       wr_data_o/wr_mask_o/wr_valid_o/wr_ready_i : line handshake
//       busy_o          : FIFO non-empty, lanes partly filled, or line pending
//       overflow_o      : sticky dropped-result flag, cleared by ovf_clr_i
//
//   Configuration
//     VPU_DST_PORT_OVF_EN : when defined, overflow_o records dropped results.
//                           When undefined, overflow_o is tied to 0.
module vpu_dst_port #(
  parameter int OPERAND_WIDTH = 32,
  parameter int LANES         = 4,
  parameter int DEPTH_LG2     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  vpu_dst_port_if.slave bus
);

  localparam int DEPTH    = 1 << DEPTH_LG2;
  localparam int PTR_W    = DEPTH_LG2 + 1;
  localparam int LANE_LG2 = $clog2(LANES);
  localparam int LINE_W   = LANES * OPERAND_WIDTH;

  typedef enum logic {
    PACK = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                   state, state_nxt;
  logic [OPERAND_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [LANE_LG2-1:0]      lane_cnt, lane_cnt_nxt;
  logic [LINE_W-1:0]        line_data, line_data_nxt;
  logic [LANES-1:0]         line_mask, line_mask_nxt;
  logic                     flush_pending, flush_pending_nxt;
  logic                     busy, busy_nxt;
  logic                     fifo_empty, fifo_full;
  logic                     pop, push, drop, handshake;
  logic [OPERAND_WIDTH-1:0] fifo_head;

  // FIFO status. The extra pointer MSB tells a full FIFO from an empty one.
  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[DEPTH_LG2] != rd_ptr[DEPTH_LG2]) &&
                 (wr_ptr[DEPTH_LG2-1:0] == rd_ptr[DEPTH_LG2-1:0]);
    fifo_head  = mem[rd_ptr[DEPTH_LG2-1:0]];
  end

  // Transfer decisions. A full FIFO still accepts a result when it pops
  // an entry in the same cycle. The write and the read then use the same
  // slot: the write lands at the edge and the read is taken before it.
  always_comb begin
    handshake  = (state == SEND) && bus.wr_ready_i;
    pop        = (state == PACK) && !fifo_empty;
    push       = bus.done_i && (!fifo_full || pop);
    drop       = bus.done_i && !push;
    wr_ptr_nxt = push ? (wr_ptr + PTR_W'(1)) : wr_ptr;
    rd_ptr_nxt = pop  ? (rd_ptr + PTR_W'(1)) : rd_ptr;
  end

  // Next-state logic for the pack/send FSM and the line being assembled.
  always_comb begin
    state_nxt         = state;
    lane_cnt_nxt      = lane_cnt;
    line_data_nxt     = line_data;
    line_mask_nxt     = line_mask;
    flush_pending_nxt = flush_pending | bus.flush_i;

    case (state)
      PACK: begin
        if (pop) begin
          for (int i = 0; i < LANES; i++) begin
            line_data_nxt[i*OPERAND_WIDTH +: OPERAND_WIDTH] =
              (lane_cnt == LANE_LG2'(i)) ? fifo_head
                                         : line_data[i*OPERAND_WIDTH +: OPERAND_WIDTH];
            line_mask_nxt[i] = (lane_cnt == LANE_LG2'(i)) ? 1'b1 : line_mask[i];
          end
          // lane_cnt wraps to 0 on the last lane. SEND keeps the line
          // marked busy until the handshake.
          lane_cnt_nxt = lane_cnt + LANE_LG2'(1);
          if (lane_cnt == LANE_LG2'(LANES - 1)) begin
            state_nxt = SEND;
          end else begin
            state_nxt = PACK;
          end
        end else if (flush_pending) begin
          // Flush is acted on only once the FIFO has drained into the lanes.
          // A flush_i arriving in this same cycle starts a new request.
          flush_pending_nxt = bus.flush_i;
          if (lane_cnt != LANE_LG2'(0)) begin
            state_nxt = SEND;
          end else begin
            state_nxt = PACK;
          end
        end else begin
          state_nxt = PACK;
        end
      end
      SEND: begin
        if (handshake) begin
          state_nxt     = PACK;
          lane_cnt_nxt  = '0;
          line_data_nxt = '0;
          line_mask_nxt = '0;
        end else begin
          state_nxt = SEND;
        end
      end
      default: begin
        state_nxt = PACK;
      end
    endcase

    busy_nxt = (wr_ptr_nxt != rd_ptr_nxt) || (lane_cnt_nxt != LANE_LG2'(0)) ||
               (state_nxt == SEND);
  end

  // State, pointer, line and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= PACK;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      lane_cnt      <= '0;
      line_data     <= '0;
      line_mask     <= '0;
      flush_pending <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      wr_ptr        <= wr_ptr_nxt;
      rd_ptr        <= rd_ptr_nxt;
      lane_cnt      <= lane_cnt_nxt;
      line_data     <= line_data_nxt;
      line_mask     <= line_mask_nxt;
      flush_pending <= flush_pending_nxt;
      busy          <= busy_nxt;
    end
  end

  // FIFO storage. Only entries between the pointers are ever read, so the
  // storage itself is not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[DEPTH_LG2-1:0]] <= bus.result_i;
    end
  end

`ifdef VPU_DST_PORT_OVF_EN
  logic overflow;

  // Sticky overflow flag. A drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (bus.ovf_clr_i) begin
      overflow <= 1'b0;
    end else begin
      overflow <= overflow;
    end
  end

  assign bus.overflow_o = overflow;
`else
  // Overflow reporting is disabled. The clear input and the drop strobe
  // have no observer.
  logic unused_ovf;
  assign unused_ovf     = bus.ovf_clr_i ^ drop;
  assign bus.overflow_o = 1'b0;
`endif

  assign bus.wr_data_o  = line_data;
  assign bus.wr_mask_o  = line_mask;
  assign bus.wr_valid_o = (state == SEND);
  assign bus.busy_o     = busy;

endmodule

// File: tb/tb_vpu_dst_port.sv
module tb_vpu_dst_port;
  localparam int W     = 32;
  localparam int L     = 4;
  localparam int DLG   = 2;
  localparam int DEPTH = 1 << DLG;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vpu_dst_port_if #(.OPERAND_WIDTH(W), .LANES(L)) bus ();

  vpu_dst_port #(.OPERAND_WIDTH(W), .LANES(L), .DEPTH_LG2(DLG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model, kept at the level of queues and flags
  logic [W-1:0] m_fifo  [$];
  logic [W-1:0] m_lanes [$];
  bit           m_send;
  bit           m_pend;
  bit           m_ovf;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_fifo.delete();
    m_lanes.delete();
    m_send = 1'b0;
    m_pend = 1'b0;
    m_ovf  = 1'b0;
  endfunction

  // Advance the model by one clock edge with the inputs of that cycle.
  function automatic void model_step(bit done, logic [W-1:0] res, bit flush, bit ready, bit clr);
    bit hs, can_pop, accepted;
    hs       = m_send && ready;
    can_pop  = !m_send && (m_fifo.size() > 0);
    accepted = done && ((m_fifo.size() < DEPTH) || can_pop);
    if (can_pop) begin
      m_lanes.push_back(m_fifo.pop_front());
      if (m_lanes.size() == L) m_send = 1'b1;
    end else if (!m_send && m_pend) begin
      if (m_lanes.size() > 0) m_send = 1'b1;
      m_pend = 1'b0;
    end
    if (hs) begin
      m_lanes.delete();
      m_send = 1'b0;
    end
    if (flush) m_pend = 1'b1;
    if (accepted) m_fifo.push_back(res);
    if (done && !accepted) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endfunction

  function automatic logic [127:0] exp_data();
    logic [127:0] d;
    d = '0;
    for (int i = 0; i < m_lanes.size(); i++) d[i*W +: W] = m_lanes[i];
    return d;
  endfunction

  function automatic logic [127:0] exp_mask();
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < m_lanes.size(); i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic bit exp_ovf();
`ifdef VPU_DST_PORT_OVF_EN
    return m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic compare_outputs(input string tag);
    bit exp_busy;
    exp_busy = (m_fifo.size() > 0) || (m_lanes.size() > 0) || m_send;
    check({tag, ".valid"}, 128'(bus.wr_valid_o), 128'(m_send));
    check({tag, ".busy"},  128'(bus.busy_o),     128'(exp_busy));
    check({tag, ".ovf"},   128'(bus.overflow_o), 128'(exp_ovf()));
    if (m_send) begin
      check({tag, ".data"}, 128'(bus.wr_data_o), exp_data());
      check({tag, ".mask"}, 128'(bus.wr_mask_o), exp_mask());
    end
  endtask

  task automatic cycle(input string tag, input bit done, input logic [W-1:0] res,
                       input bit flush, input bit ready, input bit clr);
    @(negedge clk);
    bus.done_i     = done;
    bus.result_i   = res;
    bus.flush_i    = flush;
    bus.wr_ready_i = ready;
    bus.ovf_clr_i  = clr;
    @(posedge clk);
    model_step(done, res, flush, ready, clr);
    #1;
    compare_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n, input bit ready);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, '0, 1'b0, ready, 1'b0);
  endtask

  logic [W-1:0] fp [4];

  initial begin
    fp[0] = 32'h3f80_0000;  // 1.0
    fp[1] = 32'h4000_0000;  // 2.0
    fp[2] = 32'h4040_0000;  // 3.0
    fp[3] = 32'h4080_0000;  // 4.0
    bus.done_i     = 1'b0;
    bus.result_i   = '0;
    bus.flush_i    = 1'b0;
    bus.wr_ready_i = 1'b0;
    bus.ovf_clr_i  = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.valid", 128'(bus.wr_valid_o), 128'd0);
    check("rst.busy",  128'(bus.busy_o),     128'd0);
    check("rst.mask",  128'(bus.wr_mask_o),  128'd0);
    check("rst.data",  128'(bus.wr_data_o),  128'd0);
    check("rst.ovf",   128'(bus.overflow_o), 128'd0);
    rst_n = 1'b1;

    // Full line with ready high: valid comes 2 cycles after the last done
    for (int i = 0; i < 4; i++) cycle("full", 1'b1, fp[i], 1'b0, 1'b1, 1'b0);
    cycle("full", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("full.lat_valid", 128'(bus.wr_valid_o), 128'd1);
    check("full.lat_data",  128'(bus.wr_data_o),  {fp[3], fp[2], fp[1], fp[0]});
    idle("full", 3, 1'b1);

    // Backpressure: ready low for 5 cycles of valid, then handshake
    for (int i = 0; i < 4; i++) cycle("bp", 1'b1, fp[i], 1'b0, 1'b0, 1'b0);
    idle("bp", 6, 1'b0);
    idle("bp", 3, 1'b1);

    // Partial line via flush
    cycle("flush", 1'b1, fp[0], 1'b0, 1'b1, 1'b0);
    cycle("flush", 1'b1, fp[1], 1'b0, 1'b1, 1'b0);
    cycle("flush", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle("flush", 3, 1'b0);
    check("flush.mask", 128'(bus.wr_mask_o), 128'h3);
    idle("flush", 3, 1'b1);

    // Flush with nothing buffered
    cycle("eflush", 1'b0, '0, 1'b1, 1'b1, 1'b0);
    idle("eflush", 4, 1'b1);

    // Overflow: nine results with ready low; the ninth is dropped
    for (int i = 0; i < 9; i++) cycle("ovf", 1'b1, W'(32'h100 + i), 1'b0, 1'b0, 1'b0);
    idle("ovf", 2, 1'b0);
    cycle("ovf_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle("ovf_drain", 12, 1'b1);

    // Reset during SEND discards the line
    for (int i = 0; i < 4; i++) cycle("rsend", 1'b1, fp[i], 1'b0, 1'b0, 1'b0);
    idle("rsend", 2, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rsend.valid", 128'(bus.wr_valid_o), 128'd0);
    check("rsend.busy",  128'(bus.busy_o),     128'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle("fresh", 1'b1, fp[3-i], 1'b0, 1'b1, 1'b0);
    idle("fresh", 3, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle("rand",
            $urandom_range(0, 99) < 60,
            W'($urandom),
            $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 5);
    end
    idle("tail", 20, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
